// File: rtl/sd_sector_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_sector_arbiter_if
// The hps_io SD sector channel as seen by the floppy sector arbiter.
//   sd_lba        sector address of the current request
//   sd_rd/sd_wr   per-drive read/write request (bit n = drive n)
//   sd_ack        high while hps_io is running the transfer
//   sd_buff_addr  buffer byte address from hps_io
//   sd_buff_dout  buffer data from hps_io (read transfers)
//   sd_buff_wr    buffer write strobe from hps_io (read transfers)
//   sd_buff_din   buffer data to hps_io (write transfers)
// Modports: master = arbiter side, slave = hps_io side.
// ---------------------------------------------------------------------------
interface sd_sector_arbiter_if #(
  parameter int LBA_W  = 32,
  parameter int BUF_AW = 9
);
  logic [LBA_W-1:0]  sd_lba;
  logic [1:0]        sd_rd;
  logic [1:0]        sd_wr;
  logic              sd_ack;
  logic [BUF_AW-1:0] sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/sd_sector_arbiter.sv
// ---------------------------------------------------------------------------
// sd_sector_arbiter
// Shares the single hps_io SD sector channel between two floppy drives.
// One sector transfer runs at a time; buffer traffic is routed to the granted
// drive, and requests to drives without an image complete locally with err.
//
// Ports
//   clk_sys, reset           system clock, synchronous active-high reset
//   img_mounted, img_size    mount/unmount pulse per drive, image size
//   req_rd, req_wr           per-drive request levels, held until done
//   req_lba0/1, req_din0/1   per-drive sector address and write data
//   done, err                one-cycle completion (and unmounted) pulses
//   buf_wr                   per-drive buffer write strobe
//   buf_addr, buf_dout       buffer address/data, broadcast to both drives
//   mounted                  per-drive mounted flag
//   sd                       hps_io sector channel (master side)
// ---------------------------------------------------------------------------
module sd_sector_arbiter #(
  parameter int LBA_W  = 32,
  parameter int BUF_AW = 9
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [1:0]         img_mounted,
  input  logic [63:0]        img_size,
  input  logic [1:0]         req_rd,
  input  logic [1:0]         req_wr,
  input  logic [LBA_W-1:0]   req_lba0,
  input  logic [LBA_W-1:0]   req_lba1,
  input  logic [7:0]         req_din0,
  input  logic [7:0]         req_din1,
  output logic [1:0]         done,
  output logic [1:0]         err,
  output logic [1:0]         buf_wr,
  output logic [BUF_AW-1:0]  buf_addr,
  output logic [7:0]         buf_dout,
  output logic [1:0]         mounted,
  sd_sector_arbiter_if.master sd
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE,
    S_COOL
  } state_t;

  state_t             state_reg;
  logic               ptr_reg;      // drive that wins a simultaneous request
  logic               gnt_reg;      // drive owning the current transfer
  logic               unmnt_reg;    // current grant completes locally with err
  logic [LBA_W-1:0]   lba_reg;
  logic [1:0]         sd_rd_reg;
  logic [1:0]         sd_wr_reg;
  logic [1:0]         done_reg;
  logic [1:0]         err_reg;

  logic [1:0]         pend;
  logic [1:0]         mounted_w;
  logic               sel;
  logic               sel_rd;
  logic [LBA_W-1:0]   sel_lba;
  logic [1:0]         sel_oh;
  logic [1:0]         gnt_oh;
  logic               xfer;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_drive
      logic mnt_reg;

      // A mount pulse with a zero size is an eject.
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          mnt_reg <= 1'b0;
        end else if (img_mounted[gi]) begin
          mnt_reg <= (img_size != 64'd0);
        end
      end

      assign mounted_w[gi] = mnt_reg;
      assign pend[gi]      = req_rd[gi] | req_wr[gi];
      // Only the granted drive sees hps_io's write strobe, and only mid-transfer.
      assign buf_wr[gi]    = xfer & sd.sd_buff_wr & gnt_oh[gi];
    end
  endgenerate

  // Rotating priority only matters when both drives are pending.
  assign sel     = (pend[0] & pend[1]) ? ptr_reg : pend[1];
  assign sel_rd  = req_rd[sel];            // read beats write within a drive
  assign sel_lba = sel ? req_lba1 : req_lba0;
  assign sel_oh  = sel ? 2'b10 : 2'b01;
  assign gnt_oh  = gnt_reg ? 2'b10 : 2'b01;
  assign xfer    = (state_reg == S_XFER);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg <= S_SYNC;
      ptr_reg   <= 1'b0;
      gnt_reg   <= 1'b0;
      unmnt_reg <= 1'b0;
      lba_reg   <= '0;
      sd_rd_reg <= 2'b00;
      sd_wr_reg <= 2'b00;
      done_reg  <= 2'b00;
      err_reg   <= 2'b00;
    end else begin
      done_reg <= 2'b00;
      err_reg  <= 2'b00;
      case (state_reg)
        // A reset may land while hps_io is still mid-transfer; let it finish.
        S_SYNC: begin
          if (!sd.sd_ack) state_reg <= S_IDLE;
        end
        S_IDLE: begin
          if (pend != 2'b00) begin
            gnt_reg <= sel;
            lba_reg <= sel_lba;
            if (!mounted_w[sel]) begin
              unmnt_reg <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              unmnt_reg <= 1'b0;
              state_reg <= S_REQ;
              if (sel_rd) sd_rd_reg <= sel_oh;
              else        sd_wr_reg <= sel_oh;
            end
          end
        end
        S_REQ: begin
          if (sd.sd_ack) begin
            sd_rd_reg <= 2'b00;
            sd_wr_reg <= 2'b00;
            state_reg <= S_XFER;
          end
        end
        S_XFER: begin
          if (!sd.sd_ack) state_reg <= S_DONE;
        end
        S_DONE: begin
          done_reg  <= gnt_oh;
          err_reg   <= unmnt_reg ? gnt_oh : 2'b00;
          ptr_reg   <= ~gnt_reg;
          state_reg <= S_COOL;
        end
        // done is visible during this cycle; a registered requester drops
        // its request on the edge back into IDLE.
        S_COOL: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_SYNC;
        end
      endcase
    end
  end

  assign done           = done_reg;
  assign err            = err_reg;
  assign mounted        = mounted_w;
  assign sd.sd_lba      = lba_reg;
  assign sd.sd_rd       = sd_rd_reg;
  assign sd.sd_wr       = sd_wr_reg;
  assign sd.sd_buff_din = xfer ? (gnt_reg ? req_din1 : req_din0) : 8'h00;
  assign buf_addr       = xfer ? sd.sd_buff_addr : '0;
  assign buf_dout       = xfer ? sd.sd_buff_dout : 8'h00;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
`timescale 1ns/1ps
module tb_sd_sector_arbiter;
  localparam int LBA_W  = 32;
  localparam int BUF_AW = 9;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [1:0]        img_mounted;
  logic [63:0]       img_size;
  logic [1:0]        req_rd, req_wr;
  logic [LBA_W-1:0]  req_lba0, req_lba1;
  logic [7:0]        req_din0, req_din1;
  logic [1:0]        done, err, buf_wr, mounted;
  logic [BUF_AW-1:0] buf_addr;
  logic [7:0]        buf_dout;

  always #5 clk_sys = ~clk_sys;

  sd_sector_arbiter_if #(.LBA_W(LBA_W), .BUF_AW(BUF_AW)) sd ();

  sd_sector_arbiter #(.LBA_W(LBA_W), .BUF_AW(BUF_AW)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_lba0    (req_lba0),
    .req_lba1    (req_lba1),
    .req_din0    (req_din0),
    .req_din1    (req_din1),
    .done        (done),
    .err         (err),
    .buf_wr      (buf_wr),
    .buf_addr    (buf_addr),
    .buf_dout    (buf_dout),
    .mounted     (mounted),
    .sd          (sd)
  );

  typedef struct packed {
    logic [1:0]       rd;
    logic [1:0]       wr;
    logic [LBA_W-1:0] lba;
  } req_t;

  typedef struct packed {
    logic [1:0]        wr;
    logic [BUF_AW-1:0] addr;
    logic [7:0]        dout;
  } buf_t;

  req_t       req_q[$];
  logic [3:0] done_q[$];   // {done, err}
  buf_t       buf_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got nothing/unexpected required expected event", name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [1:0] prev_req = 2'b00;
  logic [1:0] req_now;
  req_t       exp_r;
  logic [3:0] exp_d;
  buf_t       exp_b;

  always @(negedge clk_sys) begin
    req_now = sd.sd_rd | sd.sd_wr;
    if (req_now != 2'b00 && prev_req == 2'b00) begin
      if (req_q.size() == 0) begin
        miss("unexpected_sd_req");
      end else begin
        exp_r = req_q.pop_front();
        check("sd_req", 64'({sd.sd_rd, sd.sd_wr, sd.sd_lba}), 64'(exp_r));
        $display("req  rd=%b wr=%b lba=0x%0h", sd.sd_rd, sd.sd_wr, sd.sd_lba);
      end
    end
    prev_req = req_now;

    if (done != 2'b00) begin
      if (done_q.size() == 0) begin
        miss("unexpected_done");
      end else begin
        exp_d = done_q.pop_front();
        check("done_err", 64'({done, err, sd.sd_rd, sd.sd_wr}), 64'({exp_d, 4'b0000}));
        $display("done done=%b err=%b", done, err);
      end
    end

    if (buf_wr != 2'b00) begin
      if (buf_q.size() == 0) begin
        miss("unexpected_buf_wr");
      end else begin
        exp_b = buf_q.pop_front();
        check("buf_write", 64'({buf_wr, buf_addr, buf_dout}), 64'(exp_b));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic mount(input logic [1:0] which, input logic [63:0] size);
    img_mounted = which;
    img_size    = size;
    tick();
    img_mounted = 2'b00;
    img_size    = 64'd0;
  endtask

  task automatic push_req(input logic [1:0] rd, input logic [1:0] wr, input logic [LBA_W-1:0] lba);
    req_t r;
    r.rd = rd; r.wr = wr; r.lba = lba;
    req_q.push_back(r);
  endtask

  // hps_io model: waits for a request, acks it, moves nbytes, drops ack.
  task automatic hps_serve(input int nbytes, input bit is_wr, input logic [7:0] exp_din,
                           input logic [1:0] drv_oh, output int lat);
    buf_t b;
    lat = 0;
    do begin
      @(negedge clk_sys);
      lat++;
    end while ((sd.sd_rd | sd.sd_wr) == 2'b00 && lat < 200);
    if ((sd.sd_rd | sd.sd_wr) == 2'b00) begin
      miss("sd_req_timeout");
      return;
    end
    tick();
    sd.sd_ack = 1'b1;
    tick();
    for (int i = 0; i < nbytes; i++) begin
      sd.sd_buff_addr = BUF_AW'(i);
      if (!is_wr) begin
        sd.sd_buff_dout = 8'(i) ^ 8'h5A;
        sd.sd_buff_wr   = 1'b1;
        b.wr = drv_oh; b.addr = BUF_AW'(i); b.dout = 8'(i) ^ 8'h5A;
        buf_q.push_back(b);
      end
      @(negedge clk_sys);
      if (i == 0) check("req_drop", 64'(sd.sd_rd | sd.sd_wr), 64'd0);
      if (is_wr) check("buff_din", 64'(sd.sd_buff_din), 64'(exp_din));
      tick();
      sd.sd_buff_wr = 1'b0;
      tick();
    end
    sd.sd_ack       = 1'b0;
    sd.sd_buff_addr = '0;
    sd.sd_buff_dout = 8'h00;
    tick();
    check("buff_din_idle", 64'(sd.sd_buff_din), 64'd0);
  endtask

  task automatic wait_done(input int drv, output int lat);
    lat = 0;
    do begin
      @(negedge clk_sys);
      lat++;
    end while (!done[drv] && lat < 200);
    if (!done[drv]) miss("done_timeout");
  endtask

  // ---------------- directed sequence ----------------
  int lat;

  initial begin
    reset = 1'b1;
    img_mounted = 2'b00; img_size = 64'd0;
    req_rd = 2'b00; req_wr = 2'b00;
    req_lba0 = '0; req_lba1 = '0; req_din0 = 8'h00; req_din1 = 8'h00;
    sd.sd_ack = 1'b0; sd.sd_buff_addr = '0; sd.sd_buff_dout = 8'h00; sd.sd_buff_wr = 1'b0;
    tick(); tick(); tick();
    check("reset_outs", 64'({done, err, buf_wr, mounted, sd.sd_rd, sd.sd_wr}), 64'd0);
    check("reset_bus", 64'({buf_addr, buf_dout, sd.sd_buff_din, sd.sd_lba}), 64'd0);
    reset = 1'b0;
    tick();
    mount(2'b11, 64'd368640);
    check("mounted_both", 64'(mounted), 64'd3);

    // simultaneous pair right after reset: drive 0 first, twice
    for (int p = 0; p < 2; p++) begin
      req_lba0 = 32'h100 + 32'(p); req_lba1 = 32'h200 + 32'(p);
      push_req(2'b01, 2'b00, 32'h100 + 32'(p));
      push_req(2'b10, 2'b00, 32'h200 + 32'(p));
      done_q.push_back(4'b0100); done_q.push_back(4'b1000);
      req_rd = 2'b11;
      hps_serve(4, 1'b0, 8'h00, 2'b01, lat);
      wait_done(0, lat); tick(); req_rd[0] = 1'b0;
      hps_serve(4, 1'b0, 8'h00, 2'b10, lat);
      wait_done(1, lat); tick(); req_rd[1] = 1'b0;
      tick();
    end

    // full 512-byte read on drive 0, request-to-sd_rd latency
    req_lba0 = 32'h12;
    push_req(2'b01, 2'b00, 32'h12);
    done_q.push_back(4'b0100);
    req_rd = 2'b01;
    hps_serve(512, 1'b0, 8'h00, 2'b01, lat);
    check("rd_latency", 64'(lat), 64'd2);
    wait_done(0, lat); tick(); req_rd = 2'b00;
    tick();

    // pointer now on drive 1: pair served drive 1 first
    req_lba0 = 32'h301; req_lba1 = 32'h300;
    push_req(2'b10, 2'b00, 32'h300);
    push_req(2'b01, 2'b00, 32'h301);
    done_q.push_back(4'b1000); done_q.push_back(4'b0100);
    req_rd = 2'b11;
    hps_serve(4, 1'b0, 8'h00, 2'b10, lat);
    wait_done(1, lat); tick(); req_rd[1] = 1'b0;
    hps_serve(4, 1'b0, 8'h00, 2'b01, lat);
    wait_done(0, lat); tick(); req_rd[0] = 1'b0;
    tick();

    // drive 1 write, data routed to hps_io
    req_lba1 = 32'h40; req_din1 = 8'hA5;
    push_req(2'b00, 2'b10, 32'h40);
    done_q.push_back(4'b1000);
    req_wr = 2'b10;
    hps_serve(4, 1'b1, 8'hA5, 2'b10, lat);
    wait_done(1, lat); tick(); req_wr = 2'b00;
    tick(); tick();
    check("lba_hold", 64'(sd.sd_lba), 64'h40);

    // drive 1 ejected: local completion with err, no sd activity
    mount(2'b10, 64'd0);
    check("mounted_eject", 64'(mounted), 64'd1);
    req_lba1 = 32'h55;
    done_q.push_back(4'b1010);
    req_rd = 2'b10;
    wait_done(1, lat);
    check("unmnt_latency", 64'(lat), 64'd3);
    tick(); req_rd = 2'b00;
    tick();
    mount(2'b10, 64'd1000);

    // drive 0 read+write together: read first, then the write
    req_lba0 = 32'h77; req_din0 = 8'h3C;
    push_req(2'b01, 2'b00, 32'h77);
    push_req(2'b00, 2'b01, 32'h77);
    done_q.push_back(4'b0100); done_q.push_back(4'b0100);
    req_rd = 2'b01; req_wr = 2'b01;
    hps_serve(4, 1'b0, 8'h00, 2'b01, lat);
    wait_done(0, lat); tick(); req_rd = 2'b00;
    hps_serve(4, 1'b1, 8'h3C, 2'b01, lat);
    wait_done(0, lat); tick(); req_wr = 2'b00;
    tick();

    // reset mid-transfer with sd_ack high
    req_lba0 = 32'h99;
    push_req(2'b01, 2'b00, 32'h99);
    req_rd = 2'b01;
    lat = 0;
    do begin
      @(negedge clk_sys);
      lat++;
    end while (sd.sd_rd == 2'b00 && lat < 200);
    tick();
    sd.sd_ack = 1'b1;
    tick();
    exp_b.wr = 2'b01; exp_b.addr = 9'd5; exp_b.dout = 8'h77;
    buf_q.push_back(exp_b);
    sd.sd_buff_addr = 9'd5; sd.sd_buff_dout = 8'h77; sd.sd_buff_wr = 1'b1;
    reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_mid_outs", 64'({done, err, buf_wr, mounted, sd.sd_rd, sd.sd_wr}), 64'd0);
    check("rst_mid_bus", 64'({buf_addr, buf_dout, sd.sd_buff_din, sd.sd_lba}), 64'd0);
    tick();
    reset = 1'b0;
    sd.sd_buff_wr = 1'b0;
    mount(2'b11, 64'd368640);
    repeat (10) tick();
    check("no_grant_ack_high", 64'(sd.sd_rd | sd.sd_wr), 64'd0);
    push_req(2'b01, 2'b00, 32'h99);
    done_q.push_back(4'b0100);
    sd.sd_ack = 1'b0;
    sd.sd_buff_addr = '0; sd.sd_buff_dout = 8'h00;
    hps_serve(4, 1'b0, 8'h00, 2'b01, lat);
    wait_done(0, lat); tick(); req_rd = 2'b00;

    repeat (5) tick();
    check("req_q_empty", 64'(req_q.size()), 64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);
    check("buf_q_empty", 64'(buf_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
